// File: rtl/matrix_pkg.sv
// Shared constants, RGB444 field bounds and FSM states for the LED matrix pixel path.
// Latency/backpressure: n/a (types and constants only).
package matrix_pkg;
    localparam int FRAME_WORDS = 2048;
    localparam int ADDR_W      = 11;
    localparam int WORD_BITS   = 16;

    localparam int R_HI = 15;
    localparam int R_LO = 12;
    localparam int G_HI = 11;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 4;

    typedef enum logic [1:0] {IDLE, RECV, FULL} state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises SPI pins into pixel_clk and flags spi_clk rising edges.
// Latency: SYNC_STAGES+1 cycles pin-to-output on all three outputs; no backpressure.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pixel_clk,
    input  logic reset,
    input  logic spi_clk,
    input  logic spi_mosi,
    input  logic spi_cs_n,
    output logic cs_active,
    output logic sck_rise,
    output logic mosi_s
);
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_hist;

    // Outputs are registered together so MOSI and CS stay aligned with the detected edge.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sck_hist  <= 1'b0;
            cs_active <= 1'b0;
            sck_rise  <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sck_hist  <= sck_sync[SYNC_STAGES-1];
            sck_rise  <= sck_sync[SYNC_STAGES-1] & ~sck_hist;
            mosi_s    <= mosi_sync[SYNC_STAGES-1];
            cs_active <= ~cs_sync[SYNC_STAGES-1];
        end
    end
endmodule

// File: rtl/spi_frame_writer.sv
// Deserialises CS-delimited SPI frames into the off-screen half of the double-buffered pixel RAM.
// Latency: write SYNC_STAGES+2 cycles after 16th spi_clk rise; no backpressure (one word per 16 SPI clocks).
module spi_frame_writer #(
    parameter int FRAME_WORDS = matrix_pkg::FRAME_WORDS,
    parameter int ADDR_W      = matrix_pkg::ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           pixel_clk,
    input  logic                           reset,
    input  logic                           spi_clk,
    input  logic                           spi_mosi,
    input  logic                           spi_cs_n,
    output logic                           wr_en,
    output logic [ADDR_W:0]                wr_addr,
    output logic [matrix_pkg::WORD_BITS-1:0] wr_data,
    output logic                           disp_bank,
    output logic                           frame_done,
    output logic                           short_frame,
    output logic                           overrun,
    input  logic                           clear_flags
);
    import matrix_pkg::*;

    localparam int              CNT_W    = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);

    logic cs_active, sck_rise, mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .cs_active (cs_active),
        .sck_rise  (sck_rise),
        .mosi_s    (mosi_s)
    );

    state_t                 state, state_nxt;
    logic [WORD_BITS-2:0]   shift_q, shift_nxt;
    logic [WORD_BITS-1:0]   word_in;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
    logic [ADDR_W-1:0]      word_idx, word_idx_nxt;
    logic                   wr_bank, bank_nxt;
    logic                   flip_pend, flip_pend_nxt;
    logic                   wr_en_nxt;
    logic [ADDR_W:0]        wr_addr_nxt;
    logic [WORD_BITS-1:0]   wr_data_nxt;
    logic                   short_set, overrun_set;

    assign word_in   = {shift_q, mosi_s};
    assign disp_bank = ~wr_bank;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state       <= IDLE;
            shift_q     <= '0;
            bit_cnt     <= '0;
            word_idx    <= '0;
            wr_bank     <= 1'b0;
            flip_pend   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_q     <= shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            word_idx    <= word_idx_nxt;
            wr_bank     <= bank_nxt;
            flip_pend   <= flip_pend_nxt;
            wr_en       <= wr_en_nxt;
            wr_addr     <= wr_addr_nxt;
            wr_data     <= wr_data_nxt;
            frame_done  <= flip_pend;
            short_frame <= clear_flags ? 1'b0 : (short_frame | short_set);
            overrun     <= clear_flags ? 1'b0 : (overrun | overrun_set);
        end
    end

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_q;
        bit_cnt_nxt   = bit_cnt;
        word_idx_nxt  = word_idx;
        flip_pend_nxt = 1'b0;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        short_set     = 1'b0;
        overrun_set   = 1'b0;
        // The flip lands one cycle after the final write, so that word goes to the old bank.
        bank_nxt      = flip_pend ? ~wr_bank : wr_bank;

        case (state)
            IDLE: begin
                bit_cnt_nxt  = '0;
                word_idx_nxt = '0;
                if (cs_active) state_nxt = RECV;
            end
            RECV: begin
                if (!cs_active) begin
                    state_nxt    = IDLE;
                    bit_cnt_nxt  = '0;
                    word_idx_nxt = '0;
                    short_set    = (word_idx != '0);
                end else if (sck_rise) begin
                    shift_nxt = word_in[WORD_BITS-2:0];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = {wr_bank, word_idx};
                        wr_data_nxt = word_in;
                        if (word_idx == LAST_IDX) begin
                            state_nxt     = FULL;
                            flip_pend_nxt = 1'b1;
                        end else begin
                            word_idx_nxt = word_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (!cs_active) begin
                    state_nxt    = IDLE;
                    bit_cnt_nxt  = '0;
                    word_idx_nxt = '0;
                end else if (sck_rise) begin
                    shift_nxt = word_in[WORD_BITS-2:0];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        overrun_set = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/spi_frame_writer.md
# spi_frame_writer

Receives the host's SPI pixel stream and writes each complete frame into the off-screen half of the double-buffered pixel RAM. Everything runs in the `pixel_clk` domain: SPI pins are oversampled, so the RAM write port and the display read side share one clock. The block sits upstream of the HUB75 scan controller. It supplies the RAM write port and the bank-select bit that tells the scan side which half to display. Frames are delimited by chip-select, and a bank flips only after a complete frame has been received.

## Interface
Parameters:
- `FRAME_WORDS`, default 2048: words per frame (64x32 panel, top and bottom halves interleaved).
- `ADDR_W`, default 11: RAM word address width within one bank.
- `SYNC_STAGES`, default 2: synchroniser depth on the SPI pins.

Ports (single clock; reset is synchronous and active-high):
- `pixel_clk` in 1: sole clock; all logic samples on the rising edge.
- `reset` in 1: synchronous, active-high.
- `spi_clk` in 1: asynchronous SPI clock, mode 0, data sampled on its rising edge.
- `spi_mosi` in 1: asynchronous serial data, MSB first.
- `spi_cs_n` in 1: asynchronous frame delimiter, active-low.
- `wr_en` out 1: one-cycle RAM write strobe.
- `wr_addr` out 12: `{wr_bank, word_index[ADDR_W-1:0]}`.
- `wr_data` out 16: RGB444 word, R[15:12] G[11:8] B[7:4], [3:0] unused.
- `disp_bank` out 1: bank the scan controller displays; always `~wr_bank`.
- `frame_done` out 1: one-cycle pulse when a bank flips.
- `short_frame` out 1: sticky; set when CS deasserts with 1..FRAME_WORDS-1 words received.
- `overrun` out 1: sticky; set when words arrive after FRAME_WORDS in one CS window.
- `clear_flags` in 1: clears both sticky flags; clear wins over a same-cycle set.

## Operation
- Synchroniser: `SYNC_STAGES` flops on each pin, plus one history flop on `spi_clk` for rising-edge detection.
- States:
  - IDLE: waits for synced CS low, then goes to RECV.
  - RECV: shifts synced MOSI into a 16-bit register on each detected `spi_clk` rise. On the 16th bit it writes the word and clears the bit count.
  - FULL: entered after word FRAME_WORDS-1 is written. Bits are counted but not written; any completed word sets `overrun`.
  - On CS high from either RECV or FULL, the block returns to IDLE.
- Frame completion: on entering FULL, `wr_bank` toggles and `frame_done` pulses.
- CS high mid-word: partial bits are discarded, bit count and word index reset to 0, and no write occurs.
- CS high in RECV with word index > 0: `short_frame` is set, the index resets, and the bank does not flip. The next frame overwrites the same bank from address 0.
- CS high with 0 words: no flag is raised.
- Word index wraps only through reset or a CS deassert, never arithmetically.
- Simultaneous CS deassert and `spi_clk` rise: the CS deassert wins and the bit is dropped.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `wr_bank=0` (so `disp_bank=1`), `frame_done=0`, `short_frame=0`, `overrun=0`, state IDLE, all counters 0.
- A reset mid-frame abandons the frame with no flag and no flip.
- Pin-to-detect latency is SYNC_STAGES+1 cycles after a pin edge.
- `wr_en` is high in the cycle after the 16th bit's edge is detected. `wr_addr` and `wr_data` are valid in the same cycle and hold until the next write.
- `frame_done` and the `wr_bank` toggle occur in the cycle after the final `wr_en`. The last word of a frame is therefore always written into the old bank.
- `spi_clk` high and low phases must each be at least SYNC_STAGES+1 `pixel_clk` cycles. Faster clocks are unsupported and unchecked.
- Sustained throughput is one word per 16 SPI clocks; no backpressure exists.

## Structure
- Package `matrix_pkg` holds:
  - `FRAME_WORDS`, `ADDR_W`, `WORD_BITS=16`
  - RGB444 field bounds (`R_HI` .. `B_LO`)
  - the state enum `{IDLE, RECV, FULL}`.
- Sub-module `spi_pin_sync`: synchronises the three pins and outputs `cs_active`, `sck_rise`, `mosi_s`. This is reused by any future SPI control port.
- The top level holds the shifter, counters, FSM and flags.

## Test plan
- Reset, then one full frame with word i = i[15:0]:
  - 2048 `wr_en` pulses, addresses 0x000..0x7FF, data 0x0000..0x07FF.
  - `frame_done` pulses once; `disp_bank` goes 1 -> 0.
- Second full frame:
  - addresses 0x800..0xFFF; `disp_bank` goes 0 -> 1.
- CS deasserted after 100 words plus 7 bits:
  - 100 writes only, `short_frame=1`, no flip.
  - The next full frame starts again at 0x000.
- 2050 words in one CS window:
  - 2048 writes, one flip, `overrun=1`, no write to 0x800/0x801.
- Reset asserted at word 500, then a full frame:
  - no flags; writes restart at 0x000 in bank 0.
- `clear_flags` held high while a short frame ends:
  - `short_frame` stays 0.
- Word 0xF0A5 sent with `spi_clk` at the minimum phase length:
  - `wr_data=0xF0A5` exactly SYNC_STAGES+2 cycles after the 16th rising pin edge.
